// File: rtl/line_arb_pkg.sv
// -----------------------------------------------------------------------------
// line_arb_pkg
// Shared types and helpers for the cacheline arbiter family.
//   arb_state_t : transaction FSM states (IDLE, BUSY, DONE)
//   ARB_RR/ARB_FIXED : arbitration mode selectors
//   rr_pick()   : rotating-start priority search over up to MAX_PORTS requesters
// -----------------------------------------------------------------------------
package line_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    localparam int MAX_PORTS = 8;
    localparam int PICK_W    = 3;

    typedef struct packed {
        logic              valid;
        logic [PICK_W-1:0] idx;
    } pick_t;

    // Search req starting at ptr, wrapping at n; the first requester found wins.
    // A start of 0 degenerates into lowest-index-wins fixed priority.
    function automatic pick_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                      input logic [PICK_W-1:0]    ptr,
                                      input int                   n);
        pick_t res;
        int    j;
        res = '0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (!res.valid && req[j[PICK_W-1:0]]) begin
                    res.valid = 1'b1;
                    res.idx   = j[PICK_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/line_arb_picker.sv
// -----------------------------------------------------------------------------
// line_arb_picker
// Purely combinational winner selection, round-robin or fixed priority.
// Ports:
//   req   [NUM_PORTS]  request vector, bit i = client i
//   ptr   [IDX_W]      round-robin start index (ignored in fixed mode)
//   valid              at least one requester present
//   idx   [IDX_W]      winning client index
// -----------------------------------------------------------------------------
module line_arb_picker
    import line_arb_pkg::*;
#(
    parameter int  NUM_PORTS = 2,
    parameter int  ARB_MODE  = ARB_RR,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic                 valid,
    output logic [IDX_W-1:0]     idx
);

    logic [MAX_PORTS-1:0] req_ext;
    logic [PICK_W-1:0]    start;
    pick_t                pick;
    logic                 pick_unused;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_PORTS-1:0] = req;
        start                  = (ARB_MODE == ARB_FIXED) ? '0 : PICK_W'(ptr);
        pick                   = rr_pick(req_ext, start, NUM_PORTS);
    end

    assign valid = pick.valid;
    assign idx   = pick.idx[IDX_W-1:0];

    // Upper index bits are always zero for configurations narrower than 8 ports.
    assign pick_unused = ^pick.idx;

endmodule

// File: rtl/line_arbiter_rr.sv
// -----------------------------------------------------------------------------
// line_arbiter_rr
// N-port whole-cacheline arbiter in front of the single L2 line port.
// One transaction at a time: IDLE (arbitrate) -> BUSY (hold mem_* until
// mem_resp) -> DONE (one-cycle cl_resp pulse, also the client's idle bubble).
// All downstream signals and the returned line are registered.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cl_read/cl_write [N]         per-client requests, held until cl_resp
//   cl_address [N*ADDR_W]        client i at [i*ADDR_W +: ADDR_W]
//   cl_wdata   [N*LINE_W]        client i at [i*LINE_W +: LINE_W]
//   cl_resp [N], cl_rdata        completion pulse (one-hot) and returned line
//   mem_read/mem_write/mem_address/mem_wdata  registered downstream request
//   mem_resp, mem_rdata          downstream completion and read line
//   grant_id                     index of the current/last owner (debug)
// Optional (macro LINE_ARB_PERF_EN):
//   perf_grant_cnt, perf_wait_cnt [N*32]  saturating per-port counters
// -----------------------------------------------------------------------------
module line_arbiter_rr
    import line_arb_pkg::*;
#(
    parameter int  NUM_PORTS = 2,
    parameter int  ADDR_W    = 32,
    parameter int  LINE_W    = 256,
    parameter int  ARB_MODE  = ARB_RR,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_PORTS-1:0]        cl_read,
    input  logic [NUM_PORTS-1:0]        cl_write,
    input  logic [NUM_PORTS*ADDR_W-1:0] cl_address,
    input  logic [NUM_PORTS*LINE_W-1:0] cl_wdata,
    output logic [NUM_PORTS-1:0]        cl_resp,
    output logic [LINE_W-1:0]           cl_rdata,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [LINE_W-1:0]           mem_wdata,
    input  logic                        mem_resp,
    input  logic [LINE_W-1:0]           mem_rdata,
`ifdef LINE_ARB_PERF_EN
    output logic [NUM_PORTS*32-1:0]     perf_grant_cnt,
    output logic [NUM_PORTS*32-1:0]     perf_wait_cnt,
`endif
    output logic [IDX_W-1:0]            grant_id
);

    arb_state_t           state_q;
    logic [IDX_W-1:0]     owner_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     ptr_d;
    logic                 mem_read_q;
    logic                 mem_write_q;
    logic [ADDR_W-1:0]    mem_address_q;
    logic [LINE_W-1:0]    mem_wdata_q;
    logic [LINE_W-1:0]    cl_rdata_q;
    logic [NUM_PORTS-1:0] cl_resp_q;

    logic [NUM_PORTS-1:0] req;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic [ADDR_W-1:0]    addr_arr  [NUM_PORTS];
    logic [LINE_W-1:0]    wdata_arr [NUM_PORTS];

    assign req = cl_read | cl_write;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_slice
            assign addr_arr[gi]  = cl_address[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = cl_wdata[gi*LINE_W +: LINE_W];
        end
    endgenerate

    line_arb_picker #(
        .NUM_PORTS (NUM_PORTS),
        .ARB_MODE  (ARB_MODE)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Pointer moves to the port after the winner; it only moves on a grant.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && pick_valid) begin
            ptr_d = (pick_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            ptr_q         <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            cl_rdata_q    <= '0;
            cl_resp_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            cl_resp_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        owner_q       <= pick_idx;
                        // A read+write on one port is illegal; the write wins.
                        mem_write_q   <= cl_write[pick_idx];
                        mem_read_q    <= ~cl_write[pick_idx];
                        mem_address_q <= addr_arr[pick_idx];
                        mem_wdata_q   <= wdata_arr[pick_idx];
                        state_q       <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_resp) begin
                        cl_rdata_q         <= mem_rdata;
                        mem_read_q         <= 1'b0;
                        mem_write_q        <= 1'b0;
                        cl_resp_q[owner_q] <= 1'b1;
                        state_q            <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cl_resp     = cl_resp_q;
    assign cl_rdata    = cl_rdata_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign grant_id    = owner_q;

`ifdef LINE_ARB_PERF_EN
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_perf
            logic [31:0] grant_cnt_q;
            logic [31:0] wait_cnt_q;
            logic        grant_hit;
            logic        wait_hit;

            assign grant_hit = (state_q == IDLE) && pick_valid && (pick_idx == IDX_W'(gi));
            // Waiting = requesting while some transaction other than ours is in flight or starting.
            assign wait_hit  = req[gi] && !((state_q != IDLE) && (owner_q == IDX_W'(gi)))
                                       && !grant_hit;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    grant_cnt_q <= '0;
                    wait_cnt_q  <= '0;
                end else begin
                    if (grant_hit && grant_cnt_q != 32'hFFFF_FFFF) begin
                        grant_cnt_q <= grant_cnt_q + 32'd1;
                    end
                    if (wait_hit && wait_cnt_q != 32'hFFFF_FFFF) begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
                    end
                end
            end

            assign perf_grant_cnt[gi*32 +: 32] = grant_cnt_q;
            assign perf_wait_cnt[gi*32 +: 32]  = wait_cnt_q;
        end
    endgenerate
`endif

    a_no_rd_wr: assert property (@(posedge clk) disable iff (!reset_n)
        !(|(cl_read & cl_write)));
    a_resp_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(cl_resp_q));
    a_busy_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (state_q == BUSY && !mem_resp) |=> ($stable(mem_address_q) && $stable(mem_wdata_q)));

endmodule
